// File: rtl/doodlejump_mem_arbiter.sv
// Two-requester arbiter in front of a single-port on-chip memory: one command per IDLE->ISSUE(->RESP) pass.
// Define DJ_MEM_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise requester 0 has fixed priority.
module doodlejump_mem_arbiter #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata,
   output logic [1:0]          dbg_state
);

   localparam int BE_W = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t              state, state_nx;
   logic                pend0, pend1;
   logic                gnt0, gnt1;
   logic [ADDR_W-1:0]   cmd_addr;
   logic [BE_W-1:0]     cmd_be;
   logic [DATA_W-1:0]   cmd_wdata;
   logic                cmd_write;
   logic                cmd_owner;
   logic [DATA_W-1:0]   rd_hold0, rd_hold1;
`ifdef DJ_MEM_ARB_ROUND_ROBIN_EN
   logic                last_gnt;
`endif

   assign pend0 = m0_read | m0_write;
   assign pend1 = m1_read | m1_write;

   // Grants exist only in IDLE and never while reset is asserted.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state == IDLE && !reset) begin
`ifdef DJ_MEM_ARB_ROUND_ROBIN_EN
         if (pend0 && pend1) begin
            gnt0 = last_gnt;
            gnt1 = !last_gnt;
         end else begin
            gnt0 = pend0;
            gnt1 = pend1;
         end
`else
         if (pend0 && pend1) begin
            gnt0 = 1'b1;
         end else begin
            gnt0 = pend0;
            gnt1 = pend1;
         end
`endif
      end
   end

   always_comb begin
      state_nx         = state;
      mem_chipselect   = 1'b0;
      mem_write        = 1'b0;
      m0_readdatavalid = 1'b0;
      m1_readdatavalid = 1'b0;
      m0_readdata      = rd_hold0;
      m1_readdata      = rd_hold1;
      case (state)
         IDLE: begin
            if (gnt0 || gnt1) state_nx = ISSUE;
         end
         ISSUE: begin
            mem_chipselect = !reset;
            mem_write      = cmd_write && !reset;
            state_nx       = cmd_write ? IDLE : RESP;
         end
         RESP: begin
            state_nx = IDLE;
            if (!reset) begin
               if (cmd_owner) begin
                  m1_readdatavalid = 1'b1;
                  m1_readdata      = mem_readdata;
               end else begin
                  m0_readdatavalid = 1'b1;
                  m0_readdata      = mem_readdata;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cmd_addr  <= '0;
         cmd_be    <= '0;
         cmd_wdata <= '0;
         cmd_write <= 1'b0;
         cmd_owner <= 1'b0;
         rd_hold0  <= '0;
         rd_hold1  <= '0;
`ifdef DJ_MEM_ARB_ROUND_ROBIN_EN
         last_gnt  <= 1'b1;
`endif
      end else begin
         state <= state_nx;
         // A simultaneous read+write from one requester is taken as a write.
         if (gnt1) begin
            cmd_owner <= 1'b1;
            cmd_addr  <= m1_address;
            cmd_write <= m1_write;
            cmd_be    <= m1_write ? m1_byteenable : '1;
            cmd_wdata <= m1_writedata;
         end else if (gnt0) begin
            cmd_owner <= 1'b0;
            cmd_addr  <= m0_address;
            cmd_write <= m0_write;
            cmd_be    <= m0_write ? m0_byteenable : '1;
            cmd_wdata <= m0_writedata;
         end
`ifdef DJ_MEM_ARB_ROUND_ROBIN_EN
         if (gnt0 || gnt1) last_gnt <= gnt1;
`endif
         if (state == RESP) begin
            if (cmd_owner) rd_hold1 <= mem_readdata;
            else           rd_hold0 <= mem_readdata;
         end
      end
   end

   assign m0_waitrequest = !gnt0;
   assign m1_waitrequest = !gnt1;
   assign mem_address    = cmd_addr;
   assign mem_byteenable = cmd_be;
   assign mem_writedata  = cmd_wdata;
   assign mem_clken      = 1'b1;
   assign dbg_state      = state;

endmodule

// File: tb/tb_doodlejump_mem_arbiter.sv
// Bench for doodlejump_mem_arbiter: behavioural memory plus a word-level reference model of contents and grants.
module tb_doodlejump_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  m0_address = '0, m1_address = '0;
   logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
   logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
   logic [31:0] m0_writedata = '0, m1_writedata = '0;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic [1:0]  mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect, mem_write, mem_clken;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata = '0;
   logic [1:0]  dbg_state;

`ifdef DJ_MEM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   int          n_checks = 0;
   int          n_fail = 0;
   int          model_last = 1;
   logic [31:0] ref_mem [4];
   logic [31:0] mem_arr [4];

   logic [1:0]  wreq;
   logic [1:0]  rdv;
   logic [31:0] rdat [2];

   always #5 clk = ~clk;

   doodlejump_mem_arbiter #(.ADDR_W(2), .DATA_W(32)) dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
      .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
      .mem_readdata(mem_readdata), .dbg_state(dbg_state)
   );

   always_comb begin
      wreq    = {m1_waitrequest, m0_waitrequest};
      rdv     = {m1_readdatavalid, m0_readdatavalid};
      rdat[0] = m0_readdata;
      rdat[1] = m1_readdata;
   end

   // Single-port memory: readdata is the word at the address sampled on the previous edge.
   always @(posedge clk) begin
      if (mem_clken) begin
         if (mem_chipselect && mem_write) begin
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) mem_arr[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
         end
         mem_readdata <= mem_arr[mem_address];
      end
   end

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic drive(input int n, input logic rd, input logic wr, input logic [1:0] a,
                        input logic [3:0] be, input logic [31:0] d);
      if (n == 0) begin
         m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
      end else begin
         m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      drive(0, 1'b1, 1'b0, 2'd1, 4'h0, 32'h0);
      drive(1, 1'b0, 1'b1, 2'd2, 4'hF, 32'h1);
      @(negedge clk);
      n_checks++; if (wreq !== 2'b11) begin n_fail++; $display("FAIL reset_waitrequest: got %b expected 11", wreq); end
      n_checks++; if (rdv !== 2'b00) begin n_fail++; $display("FAIL reset_readdatavalid: got %b expected 00", rdv); end
      n_checks++; if (mem_chipselect !== 1'b0) begin n_fail++; $display("FAIL reset_chipselect: got %b expected 0", mem_chipselect); end
      n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_mem_write: got %b expected 0", mem_write); end
      n_checks++; if (mem_clken !== 1'b1) begin n_fail++; $display("FAIL reset_clken: got %b expected 1", mem_clken); end
      n_checks++; if (m0_readdata !== 32'h0) begin n_fail++; $display("FAIL reset_m0_readdata: got %h expected 0", m0_readdata); end
      n_checks++; if (m1_readdata !== 32'h0) begin n_fail++; $display("FAIL reset_m1_readdata: got %h expected 0", m1_readdata); end
      @(posedge clk); #1;
      reset = 1'b0;
      drive(0, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0);
      model_last = 1;
   endtask

   // One uncontended transaction on port n, checked cycle by cycle against the reference model.
   task automatic single_txn(input int n, input logic rd, input logic wr, input logic [1:0] a,
                             input logic [3:0] be, input logic [31:0] d);
      int          budget;
      logic [3:0]  exp_be;
      logic [31:0] exp_rd;
      exp_be = wr ? be : 4'hF;
      @(posedge clk); #1;
      drive(n, rd, wr, a, be, d);
      budget = 0;
      do begin
         @(negedge clk); budget++;
      end while (wreq[n] !== 1'b0 && budget < 10);
      n_checks++;
      if (wreq[n] !== 1'b0) begin
         n_fail++;
         $display("FAIL txn_accept: port %0d waitrequest %b after %0d cycles, required 0", n, wreq[n], budget);
         drive(n, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0);
         return;
      end
      n_checks++; if (wreq[1-n] !== 1'b1) begin n_fail++; $display("FAIL txn_other_wait: port %0d got %b expected 1", 1-n, wreq[1-n]); end
      @(posedge clk); #1;
      drive(n, 1'b0, 1'b0, a, be, d);
      @(negedge clk);
      n_checks++; if (mem_chipselect !== 1'b1) begin n_fail++; $display("FAIL txn_issue_cs: got %b expected 1", mem_chipselect); end
      n_checks++; if (mem_write !== wr) begin n_fail++; $display("FAIL txn_issue_write: got %b expected %b", mem_write, wr); end
      n_checks++; if (mem_address !== a) begin n_fail++; $display("FAIL txn_issue_addr: got %0d expected %0d", mem_address, a); end
      n_checks++; if (mem_byteenable !== exp_be) begin n_fail++; $display("FAIL txn_issue_be: got %h expected %h", mem_byteenable, exp_be); end
      n_checks++; if (wreq !== 2'b11) begin n_fail++; $display("FAIL txn_issue_wait: got %b expected 11", wreq); end
      if (wr) begin
         n_checks++; if (mem_writedata !== d) begin n_fail++; $display("FAIL txn_issue_wdata: got %h expected %h", mem_writedata, d); end
         ref_mem[a] = merge(ref_mem[a], d, be);
         @(negedge clk);
         n_checks++; if (mem_chipselect !== 1'b0) begin n_fail++; $display("FAIL txn_post_write_cs: got %b expected 0", mem_chipselect); end
         n_checks++; if (rdv !== 2'b00) begin n_fail++; $display("FAIL txn_write_no_rdv: got %b expected 00", rdv); end
      end else begin
         exp_rd = ref_mem[a];
         @(negedge clk);
         n_checks++; if (rdv !== (n == 0 ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL txn_rdv: port %0d got %b", n, rdv); end
         n_checks++; if (rdat[n] !== exp_rd) begin n_fail++; $display("FAIL txn_rdata: got %h expected %h", rdat[n], exp_rd); end
         n_checks++; if (mem_chipselect !== 1'b0) begin n_fail++; $display("FAIL txn_resp_cs: got %b expected 0", mem_chipselect); end
         @(negedge clk);
         n_checks++; if (rdv !== 2'b00) begin n_fail++; $display("FAIL txn_rdv_single: got %b expected 00", rdv); end
         n_checks++; if (rdat[n] !== exp_rd) begin n_fail++; $display("FAIL txn_rdata_hold: got %h expected %h", rdat[n], exp_rd); end
      end
      model_last = n;
   endtask

   task automatic test_write_read();
      single_txn(0, 1'b0, 1'b1, 2'd2, 4'hF, 32'hDEADBEEF);
      single_txn(0, 1'b1, 1'b0, 2'd2, 4'h0, 32'h0);
      n_checks++; if (m0_readdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_read_value: got %h expected deadbeef", m0_readdata); end
   endtask

   task automatic test_byteenable();
      single_txn(1, 1'b0, 1'b1, 2'd1, 4'hF, 32'hFFFFFFFF);
      single_txn(1, 1'b0, 1'b1, 2'd1, 4'h3, 32'h12345678);
      single_txn(1, 1'b1, 1'b0, 2'd1, 4'h0, 32'h0);
      n_checks++; if (m1_readdata !== 32'hFFFF5678) begin n_fail++; $display("FAIL byteenable_value: got %h expected ffff5678", m1_readdata); end
   endtask

   task automatic test_read_write_both();
      single_txn(0, 1'b1, 1'b1, 2'd3, 4'hF, 32'hA5A5A5A5);
      single_txn(0, 1'b1, 1'b0, 2'd3, 4'h0, 32'h0);
      n_checks++; if (m0_readdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL rw_both_value: got %h expected a5a5a5a5", m0_readdata); end
   endtask

   // Both requesters hold reads for three transactions each; the grant order comes from the arbitration rule.
   task automatic test_contention();
      int          rem [2];
      logic [1:0]  a [2];
      int          budget, got, exp_w;
      logic [31:0] exp_rd;
      a[0] = 2'($urandom_range(0, 3));
      a[1] = 2'($urandom_range(0, 3));
      rem[0] = 3; rem[1] = 3;
      @(posedge clk); #1;
      drive(0, 1'b1, 1'b0, a[0], 4'h0, 32'h0);
      drive(1, 1'b1, 1'b0, a[1], 4'h0, 32'h0);
      budget = 0;
      while ((rem[0] > 0 || rem[1] > 0) && budget < 60) begin
         @(negedge clk); budget++;
         if (wreq !== 2'b11) begin
            n_checks++; if (wreq === 2'b00) begin n_fail++; $display("FAIL cont_double_grant: got %b", wreq); end
            got = (wreq[0] === 1'b0) ? 0 : 1;
            if (rem[0] > 0 && rem[1] > 0) exp_w = RR ? (model_last == 0 ? 1 : 0) : 0;
            else                          exp_w = (rem[0] > 0) ? 0 : 1;
            n_checks++; if (got != exp_w) begin n_fail++; $display("FAIL cont_grant_order: got m%0d expected m%0d", got, exp_w); end
            model_last = exp_w;
            @(posedge clk); #1;
            rem[got]--;
            if (rem[got] <= 0) drive(got, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0);
            @(negedge clk);
            n_checks++; if (mem_chipselect !== 1'b1 || mem_write !== 1'b0) begin n_fail++; $display("FAIL cont_issue: cs %b write %b expected 1 0", mem_chipselect, mem_write); end
            n_checks++; if (mem_address !== a[got]) begin n_fail++; $display("FAIL cont_addr: got %0d expected %0d", mem_address, a[got]); end
            n_checks++; if (wreq !== 2'b11) begin n_fail++; $display("FAIL cont_holdoff: got %b expected 11", wreq); end
            exp_rd = ref_mem[a[got]];
            @(negedge clk);
            n_checks++; if (rdv !== (got == 0 ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL cont_rdv_owner: got %b for m%0d", rdv, got); end
            n_checks++; if (rdat[got] !== exp_rd) begin n_fail++; $display("FAIL cont_rdata: got %h expected %h", rdat[got], exp_rd); end
         end
      end
      n_checks++;
      if (rem[0] > 0 || rem[1] > 0) begin n_fail++; $display("FAIL cont_timeout: remaining m0 %0d m1 %0d expected 0 0", rem[0], rem[1]); end
      drive(0, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0);
   endtask

   task automatic test_reset_mid();
      logic [31:0] exp_rd;
      @(posedge clk); #1;
      drive(1, 1'b1, 1'b0, 2'd1, 4'h0, 32'h0);
      @(negedge clk);
      n_checks++; if (wreq !== 2'b01) begin n_fail++; $display("FAIL rstmid_grant: got %b expected 01", wreq); end
      @(posedge clk); #1;
      drive(1, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0);
      @(negedge clk);
      n_checks++; if (mem_chipselect !== 1'b1) begin n_fail++; $display("FAIL rstmid_issue: got %b expected 1", mem_chipselect); end
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      n_checks++; if (rdv !== 2'b00) begin n_fail++; $display("FAIL rstmid_no_rdv: got %b expected 00", rdv); end
      n_checks++; if (wreq !== 2'b11) begin n_fail++; $display("FAIL rstmid_wait: got %b expected 11", wreq); end
      n_checks++; if (mem_chipselect !== 1'b0) begin n_fail++; $display("FAIL rstmid_cs: got %b expected 0", mem_chipselect); end
      @(posedge clk); #1;
      reset = 1'b0;
      model_last = 1;
      drive(0, 1'b1, 1'b0, 2'd3, 4'h0, 32'h0);
      drive(1, 1'b1, 1'b0, 2'd0, 4'h0, 32'h0);
      @(negedge clk);
      n_checks++; if (wreq !== 2'b10) begin n_fail++; $display("FAIL rstmid_first_grant: got %b expected 10", wreq); end
      n_checks++; if (rdv !== 2'b00) begin n_fail++; $display("FAIL rstmid_late_rdv: got %b expected 00", rdv); end
      n_checks++; if (m1_readdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_m1_readdata: got %h expected 0", m1_readdata); end
      exp_rd = ref_mem[3];
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0);
      @(negedge clk);
      @(negedge clk);
      n_checks++; if (rdv !== 2'b01) begin n_fail++; $display("FAIL rstmid_read_rdv: got %b expected 01", rdv); end
      n_checks++; if (m0_readdata !== exp_rd) begin n_fail++; $display("FAIL rstmid_read_data: got %h expected %h", m0_readdata, exp_rd); end
      model_last = 0;
   endtask

   task automatic test_random();
      int          n;
      logic        rd, wr;
      for (int i = 0; i < 24; i++) begin
         n  = int'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
         single_txn(n, rd, wr, 2'($urandom_range(0, 3)), 4'($urandom_range(1, 15)), $urandom);
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         ref_mem[i] = 32'h0;
         mem_arr[i] = 32'h0;
      end
      test_reset();
      test_write_read();
      test_byteenable();
      test_read_write_both();
      test_contention();
      test_reset_mid();
      test_random();
      test_contention();
      test_random();
      test_contention();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/doodlejump_mem_arbiter.md
DOODLEJUMP_MEM_ARBITER -- requirements
Module: doodlejump_mem_arbiter

Interface
REQ-001 SHALL provide parameter ADDR_W, default 2, word-address width of the shared on-chip memory (4 words).
REQ-002 SHALL provide parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 SHALL use one clock; reset is synchronous and active-high; ports named clk and reset.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 mN_address  in  ADDR_W  requester N word address (N = 0, 1 throughout).
REQ-007 mN_byteenable  in  DATA_W/8  requester N byte lanes for writes.
REQ-008 mN_read  in  1  requester N read request.
REQ-009 mN_write  in  1  requester N write request.
REQ-010 mN_writedata  in  DATA_W  requester N write data.
REQ-011 mN_waitrequest  out  1  high = requester N command not accepted this cycle.
REQ-012 mN_readdata  out  DATA_W  read data returned to requester N.
REQ-013 mN_readdatavalid  out  1  one-cycle strobe qualifying mN_readdata.
REQ-014 mem_address  out  ADDR_W  to memory address port.
REQ-015 mem_byteenable  out  DATA_W/8  to memory byteenable.
REQ-016 mem_chipselect  out  1  to memory chipselect.
REQ-017 mem_write  out  1  to memory write.
REQ-018 mem_writedata  out  DATA_W  to memory writedata.
REQ-019 mem_clken  out  1  to memory clken; constant 1.
REQ-020 mem_readdata  in  DATA_W  from memory readdata (valid the cycle after the address is sampled).

Function
REQ-021 FSM SHALL have states IDLE, ISSUE, RESP.
REQ-022 IDLE: requester N is pending when mN_read or mN_write is high; if one is pending it is granted; if both, arbitration per REQ-030.
REQ-023 Grant SHALL drive the winner's mN_waitrequest low combinationally in the same IDLE cycle; the loser's waitrequest stays high; the command (address, byteenable, writedata, read/write, owner id) is registered; next state ISSUE.
REQ-024 mN_waitrequest SHALL be high whenever the FSM is not in IDLE or N is not granted.
REQ-025 ISSUE: mem_chipselect = 1 with registered command for exactly one cycle; write -> IDLE, read -> RESP.
REQ-026 mem_chipselect, mem_write SHALL be 0 in every cycle other than ISSUE; mem_byteenable SHALL be all ones for reads.
REQ-027 RESP: mOwner_readdatavalid = 1 and mOwner_readdata = mem_readdata for one cycle; other requester's readdatavalid = 0; next state IDLE.
REQ-028 Latency: write accept -> memory write 1 cycle; read accept -> readdatavalid 2 cycles; max throughput one write per 2 cycles, one read per 3 cycles.
REQ-029 mN_readdata outside RESP SHALL hold its last value (0 after reset).
REQ-030 Both pending in IDLE: winner per Configuration; the grant owner register updates on every grant.
REQ-031 Same requester asserting read and write together: write SHALL win; read ignored for that acceptance.
REQ-032 Requests asserted outside IDLE SHALL be held off (waitrequest high) with no effect until IDLE.

Reset
REQ-033 reset high SHALL force state IDLE, last-grant register = 1 (so requester 0 wins the first contention), all registered command fields 0.
REQ-034 During reset: both waitrequest = 1, both readdatavalid = 0, mem_chipselect = 0, mem_write = 0, mem_clken = 1.
REQ-035 Reset mid-operation SHALL abort: an issued-but-unreturned read produces no readdatavalid; a write in ISSUE at the reset edge is not guaranteed.

Configuration
REQ-036 Macro DJ_MEM_ARB_ROUND_ROBIN_EN defined: on contention, grant the requester not granted last.
REQ-037 Macro undefined: fixed priority, requester 0 always wins contention; last-grant register may be omitted.

Verification
REQ-038 m0 write addr 2, data 0xDEADBEEF, be 0xF -> waitrequest low 1 cycle, next cycle mem_chipselect=1, mem_write=1, mem_address=2; later m0 read addr 2 -> m0_readdatavalid 2 cycles after accept with 0xDEADBEEF.
REQ-039 m0 and m1 read simultaneously, held 3 transactions each, RR enabled -> grant order m0, m1, m0, m1, ...; readdatavalid only on owning port.
REQ-040 Same contention with macro undefined -> m0 granted continuously while requesting; m1 granted only after m0 deasserts.
REQ-041 m1 write be 0x3 data 0x12345678 to addr 1 over prior 0xFFFFFFFF -> subsequent read returns 0xFFFF5678.
REQ-042 reset asserted in RESP-pending read (cycle after ISSUE) -> no readdatavalid, both waitrequest high, mem_chipselect 0; after release m0 request granted first.
REQ-043 m0 asserts read and write together, addr 3, data 0xA5A5A5A5 -> write performed, no readdatavalid.
